// File: rtl/ovf_case_monitor.sv
// Runtime monitor for unsigned add/mul overflow and unmatched case selectors.
// Saturating event counters; snapshots are handed out over a valid/ready report port.
module ovf_case_monitor #(
  parameter int unsigned          W           = 4,
  parameter int unsigned          SEL_W       = 2,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [2**SEL_W-1:0]  CASE_MASK   = 4'b0111,
  parameter bit                   CLR_ON_READ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [SEL_W-1:0] sel,
  input  logic             rpt_req,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_add_cnt,
  output logic [CNT_W-1:0] rpt_mul_cnt,
  output logic [CNT_W-1:0] rpt_miss_cnt,
  output logic             sticky_any
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_nxt;

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [SEL_W-1:0] s1_sel;

  logic [W:0]       sum;
  logic [2*W-1:0]   prod;
  logic [2:0]       ev;

  logic [2:0][CNT_W-1:0] live;
  logic [2:0][CNT_W-1:0] delta;

  logic take_snap;
  logic handshake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic e);
    return (e && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Stage 1: sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= op_a;
        s1_b   <= op_b;
        s1_sel <= sel;
      end
    end
  end

  // Stage 2: event detection on the registered sample
  always_comb begin
    sum   = {1'b0, s1_a} + {1'b0, s1_b};
    prod  = {{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_b};
    ev    = '0;
    ev[0] = s1_valid & sum[W];
    ev[1] = s1_valid & (|prod[2*W-1:W]);
    ev[2] = s1_valid & ~CASE_MASK[s1_sel];
  end

  // Report FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Report FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rpt_req)   state_nxt = HOLD;
      HOLD:    if (rpt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Report FSM: outputs and strobes
  always_comb begin
    rpt_valid = 1'b0;
    take_snap = 1'b0;
    handshake = 1'b0;
    unique case (state)
      IDLE: take_snap = rpt_req;
      HOLD: begin
        rpt_valid = 1'b1;
        handshake = rpt_ready;
      end
      default: ;
    endcase
  end

  // delta tracks events since the snapshot so a clearing handshake keeps them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live  <= '0;
      delta <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (handshake && CLR_ON_READ) begin
          live[i] <= sat_inc(delta[i], ev[i]);
        end else begin
          live[i] <= sat_inc(live[i], ev[i]);
        end
        if (take_snap) begin
          delta[i] <= CNT_W'(ev[i]);
        end else if (state == HOLD) begin
          delta[i] <= sat_inc(delta[i], ev[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_add_cnt  <= '0;
      rpt_mul_cnt  <= '0;
      rpt_miss_cnt <= '0;
    end else if (take_snap) begin
      rpt_add_cnt  <= live[0];
      rpt_mul_cnt  <= live[1];
      rpt_miss_cnt <= live[2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_any <= 1'b0;
    end else if (handshake && CLR_ON_READ) begin
      sticky_any <= |ev;
    end else if (|ev) begin
      sticky_any <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ovf_case_monitor.sv
// Randomized bench for ovf_case_monitor: expected snapshots are queued by a
// per-cycle reference model and checked by an independent report monitor.
module tb_ovf_case_monitor;

  localparam int unsigned W     = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [3:0]  MASK  = 4'b0111;
  localparam int          SATV  = 255;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [SEL_W-1:0] sel;
  logic             rpt_req;
  logic             rpt_ready;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_add_cnt;
  logic [CNT_W-1:0] rpt_mul_cnt;
  logic [CNT_W-1:0] rpt_miss_cnt;
  logic             sticky_any;

  ovf_case_monitor #(
    .W(W), .SEL_W(SEL_W), .CNT_W(CNT_W), .CASE_MASK(MASK), .CLR_ON_READ(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op_a(op_a), .op_b(op_b), .sel(sel),
    .rpt_req(rpt_req), .rpt_ready(rpt_ready), .rpt_valid(rpt_valid),
    .rpt_add_cnt(rpt_add_cnt), .rpt_mul_cnt(rpt_mul_cnt), .rpt_miss_cnt(rpt_miss_cnt),
    .sticky_any(sticky_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int add; int mul; int miss; } snap_t;

  int    total = 0;
  int    bad   = 0;
  snap_t expq[$];

  // Reference model state: events in flight, live/since-snapshot counts
  bit [2:0] m_pend;
  int       m_live[3];
  int       m_delta[3];
  bit       m_sticky;
  bit       m_busy;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [2:0] evs(input int a, input int b, input int s);
    bit [2:0] r;
    r[0] = (a + b) > 15;
    r[1] = (a * b) > 15;
    r[2] = ((int'(MASK) >> s) & 1) == 0;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > SATV) ? SATV : v;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_sticky = 0; m_busy = 0;
    for (int i = 0; i < 3; i++) begin m_live[i] = 0; m_delta[i] = 0; end
  endtask

  task automatic model_step();
    bit [2:0] ev;
    snap_t s;
    ev = m_pend;
    if (!m_busy) begin
      if (rpt_req) begin
        s.add = m_live[0]; s.mul = m_live[1]; s.miss = m_live[2];
        expq.push_back(s);
        for (int i = 0; i < 3; i++) m_delta[i] = int'(ev[i]);
        m_busy = 1;
      end
      for (int i = 0; i < 3; i++) m_live[i] = sat(m_live[i] + int'(ev[i]));
      if (|ev) m_sticky = 1;
    end else begin
      if (rpt_ready) begin
        m_busy = 0;
        for (int i = 0; i < 3; i++) m_live[i] = sat(m_delta[i] + int'(ev[i]));
        m_sticky = |ev;
      end else begin
        for (int i = 0; i < 3; i++) m_live[i] = sat(m_live[i] + int'(ev[i]));
        if (|ev) m_sticky = 1;
      end
      for (int i = 0; i < 3; i++) m_delta[i] = sat(m_delta[i] + int'(ev[i]));
    end
    m_pend = in_valid ? evs(int'(op_a), int'(op_b), int'(sel)) : 3'b000;
  endtask

  task automatic cyc(input bit v, input int a, input int b, input int s,
                     input bit req, input bit rdy);
    in_valid  = v;
    op_a      = a[W-1:0];
    op_b      = b[W-1:0];
    sel       = s[SEL_W-1:0];
    rpt_req   = req;
    rpt_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sticky_any", int'(sticky_any), int'(m_sticky));
    chk("rpt_valid", int'(rpt_valid), int'(m_busy));
    #1;
  endtask

  task automatic snap();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Report monitor: pops one expectation per report and checks it every held cycle
  bit    seen = 0;
  snap_t cur;
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (rpt_valid) begin
      if (!seen) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_report: got valid=1 want no report");
        end else begin
          cur  = expq.pop_front();
          seen = 1;
        end
      end
      if (seen) begin
        chk("rpt_add_cnt", int'(rpt_add_cnt), cur.add);
        chk("rpt_mul_cnt", int'(rpt_mul_cnt), cur.mul);
        chk("rpt_miss_cnt", int'(rpt_miss_cnt), cur.miss);
      end
    end else begin
      seen = 0;
    end
  end

  initial begin
    rst = 1; in_valid = 0; op_a = '0; op_b = '0; sel = '0; rpt_req = 0; rpt_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid", int'(rpt_valid), 0);
    chk("reset_add", int'(rpt_add_cnt), 0);
    chk("reset_mul", int'(rpt_mul_cnt), 0);
    chk("reset_miss", int'(rpt_miss_cnt), 0);
    chk("reset_sticky", int'(sticky_any), 0);
    rst = 0;
    #1;

    // add overflow; first snapshot coincides with the event (pre-increment)
    cyc(1, 9, 8, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    snap();
    cyc(1, 7, 8, 0, 0, 0);
    snap();

    // multiply
    cyc(1, 3, 5, 0, 0, 0);
    snap();
    cyc(1, 4, 4, 1, 0, 0);
    snap();
    cyc(1, 15, 15, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    snap();

    // selector sweep and gated sample
    for (int s = 0; s < 4; s++) cyc(1, 0, 0, s, 0, 0);
    cyc(0, 0, 0, 3, 0, 0);
    cyc(0, 0, 0, 3, 0, 0);
    snap();

    // saturation
    for (int i = 0; i < 300; i++) cyc(1, 15, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    snap();

    // held report with ongoing events, ignored re-request, coincident handshake event
    cyc(1, 15, 15, 3, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 15, 15, 3, (i == 2), 0);
    cyc(1, 9, 9, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    snap();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // async reset in the middle of a held report
    cyc(1, 15, 15, 3, 0, 0);
    cyc(1, 15, 15, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1;
    #1;
    chk("midrst_valid", int'(rpt_valid), 0);
    chk("midrst_add", int'(rpt_add_cnt), 0);
    chk("midrst_mul", int'(rpt_mul_cnt), 0);
    chk("midrst_miss", int'(rpt_miss_cnt), 0);
    chk("midrst_sticky", int'(sticky_any), 0);
    model_reset();
    expq.delete();
    in_valid = 0; rpt_req = 0; rpt_ready = 0;
    @(negedge clk);
    rst = 0;
    #1;
    cyc(1, 8, 8, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    snap();

    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL pending_reports: got %0d outstanding want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
